// File: rtl/risc_v_mike_fetch_unit.sv
// Single-issue instruction fetch stage: PC register, combinational instruction-memory
// read, one-entry decode buffer with ready/valid handshake, redirect and halt handling.
module risc_v_mike_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 5,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rd_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc_plus4,
  output logic                   fetch_err,
  output logic [31:0]            fetch_count
);

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    FETCH  = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        advance;
  logic        redirect_aligned;
  logic        handshake;

  // Upper PC bits are dropped so the fetch address wraps over the memory size.
  assign imem_addr        = pc[IMEM_ADDR_W+1:2];
  assign id_pc_plus4      = id_pc + 32'd4;
  assign advance          = !id_valid || id_ready;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
  assign handshake        = id_valid && id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BUBBLE;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A handshake completes even on the edge that a redirect flushes the buffer.
      if (handshake) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        HALT: begin
          id_valid <= 1'b0;
        end

        default: begin
          if (redirect_valid) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            if (redirect_aligned) begin
              pc    <= redirect_pc;
              state <= BUBBLE;
            end else begin
              fetch_err <= 1'b1;
              state     <= HALT;
            end
          end else if (state == BUBBLE) begin
            state <= FETCH;
          end else if (advance) begin
            id_instr <= imem_rd_data;
            id_pc    <= pc;
            id_valid <= 1'b1;
            pc       <= pc + 32'd4;
          end
        end
      endcase
    end
  end

endmodule
